// File: rtl/toggle_sequencer.sv
// -----------------------------------------------------------------------------
// toggle_sequencer
//
// Holds an N-bit data register and a small command FIFO of bit indices.
// Commands are queued at any time while the FIFO has room. On i_start the
// sequencer drains the FIFO one command per cycle and flips the addressed
// bit of the data register. Indices that are negative (sign bit set) or out
// of range (modulus >= N) leave the data untouched and raise a sticky error.
//
// Parameters
//   N      data width and bit-index field width
//   DEPTH  command FIFO depth (power of two, >= 2)
//
// Ports
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_load     load i_a into the data register (IDLE only)
//   i_a        load value
//   i_valid    command present on i_b
//   o_ready    FIFO not full
//   i_b        command: [N-1] sign, [N-2:0] bit index modulus
//   i_start    begin draining the FIFO (IDLE only)
//   o_out      data register
//   o_busy     high while draining (RUN)
//   o_done     one-cycle completion pulse (DONE)
//   o_ERR      sticky invalid-index flag, cleared by i_load
//   o_err_cnt  (only with TOGGLE_ERR_CNT_EN) saturating count of invalid
//              commands, cleared by i_load
//
// Build option
//   TOGGLE_ERR_CNT_EN  adds the o_err_cnt output and its counter.
// -----------------------------------------------------------------------------
module toggle_sequencer #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [N-1:0] i_a,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_b,
  input  logic         i_start,
  output logic [N-1:0] o_out,
  output logic         o_busy,
  output logic         o_done,
`ifdef TOGGLE_ERR_CNT_EN
  output logic         o_ERR,
  output logic [7:0]   o_err_cnt
`else
  output logic         o_ERR
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A command is unusable if it is negative or addresses a bit beyond N-1.
  function automatic logic is_invalid(input logic [N-1:0] cmd);
    logic [31:0] modulus;
    modulus    = 32'(cmd[N-2:0]);
    is_invalid = cmd[N-1] || (modulus >= 32'(N));
  endfunction

  // One-hot mask for the addressed bit; only meaningful for valid commands.
  function automatic logic [N-1:0] toggle_mask(input logic [N-1:0] cmd);
    toggle_mask = '0;
    toggle_mask[cmd[IDX_W-1:0]] = 1'b1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t           state;
  state_t           state_nxt;

  logic [N-1:0]     fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;

  logic             push;
  logic             pop;
  logic             do_load;
  logic [N-1:0]     head;
  logic             head_bad;

  assign o_ready  = (fifo_cnt != CNT_FULL);
  assign push     = i_valid && o_ready;
  assign head     = fifo_mem[rd_ptr];
  assign head_bad = is_invalid(head);

  assign o_busy   = (state == RUN);
  assign o_done   = (state == DONE);

  // FSM next-state and per-cycle control.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    do_load   = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_load) begin
          do_load = 1'b1;
        end else if (i_start) begin
          state_nxt = (fifo_cnt != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        pop = (fifo_cnt != '0);
        // Leaving RUN only when the last entry goes out and nothing refills it.
        if ((fifo_cnt <= CNT_ONE) && !push) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FIFO storage is plain data and carries no reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= i_b;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Data register and sticky error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_out <= '0;
      o_ERR <= 1'b0;
    end else if (do_load) begin
      o_out <= i_a;
      o_ERR <= 1'b0;
    end else if (pop) begin
      if (head_bad) begin
        o_ERR <= 1'b1;
      end else begin
        o_out <= o_out ^ toggle_mask(head);
      end
    end
  end

`ifdef TOGGLE_ERR_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_cnt <= 8'd0;
    end else if (do_load) begin
      o_err_cnt <= 8'd0;
    end else if (pop && head_bad) begin
      o_err_cnt <= sat_inc8(o_err_cnt);
    end
  end
`else
  // Without the counter the saturating helper has no user; nothing to build.
`endif

endmodule

// File: tb/tb_toggle_sequencer.sv
module tb_toggle_sequencer;

  localparam int N     = 8;
  localparam int DEPTH = 4;

  logic         clk;
  logic         rst_n;
  logic         load;
  logic [N-1:0] a;
  logic         valid;
  logic         ready;
  logic [N-1:0] b;
  logic         start;
  logic [N-1:0] out;
  logic         busy;
  logic         done;
  logic         err;
`ifdef TOGGLE_ERR_CNT_EN
  logic [7:0]   err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  toggle_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_load   (load),
    .i_a      (a),
    .i_valid  (valid),
    .o_ready  (ready),
    .i_b      (b),
    .i_start  (start),
    .o_out    (out),
    .o_busy   (busy),
    .o_done   (done),
`ifdef TOGGLE_ERR_CNT_EN
    .o_ERR    (err),
    .o_err_cnt(err_cnt)
`else
    .o_ERR    (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [N-1:0] v);
    load = 1'b1;
    a    = v;
    tick();
    load = 1'b0;
  endtask

  task automatic do_push(input logic [N-1:0] v);
    valid = 1'b1;
    b     = v;
    tick();
    valid = 1'b0;
  endtask

  // Pulse start, then count busy and done cycles until the done pulse ends.
  task automatic run(output int busy_n, output int done_n);
    busy_n = 0;
    done_n = 0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy) busy_n++;
      if (done) done_n++;
      else if (done_n > 0) break;
      tick();
    end
  endtask

  int bn, dn, dseen;

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    a     = '0;
    valid = 1'b0;
    b     = '0;
    start = 1'b0;
    #12;
    check("rst_out",   32'(out),   32'h00);
    check("rst_ready", 32'(ready), 32'h1);
    check("rst_busy",  32'(busy),  32'h0);
    check("rst_done",  32'(done),  32'h0);
    check("rst_err",   32'(err),   32'h0);
`ifdef TOGGLE_ERR_CNT_EN
    check("rst_cnt",   32'(err_cnt), 32'h0);
`endif
    rst_n = 1'b1;
    tick();

    // A5 ^ bit0 ^ bit7 = 24
    do_load(8'hA5);
    check("t1_load", 32'(out), 32'hA5);
    do_push(8'h00);
    do_push(8'h07);
    run(bn, dn);
    check("t1_busy", 32'(bn), 32'd2);
    check("t1_done", 32'(dn), 32'd1);
    check("t1_out",  32'(out), 32'h24);
    check("t1_err",  32'(err), 32'h0);

    // 08 out of range, 83 negative, 03 valid
    do_load(8'h00);
    do_push(8'h08);
    do_push(8'h83);
    do_push(8'h03);
    run(bn, dn);
    check("t2_busy", 32'(bn), 32'd3);
    check("t2_out",  32'(out), 32'h08);
    check("t2_err",  32'(err), 32'h1);
`ifdef TOGGLE_ERR_CNT_EN
    check("t2_cnt",  32'(err_cnt), 32'd2);
`endif

    // Fill the FIFO; fifth push is dropped
    do_load(8'h00);
    check("t3_err_clr", 32'(err), 32'h0);
`ifdef TOGGLE_ERR_CNT_EN
    check("t3_cnt_clr", 32'(err_cnt), 32'd0);
`endif
    do_push(8'h00);
    do_push(8'h01);
    do_push(8'h02);
    check("t3_ready3", 32'(ready), 32'h1);
    do_push(8'h03);
    check("t3_ready4", 32'(ready), 32'h0);
    do_push(8'h04);
    check("t3_ready5", 32'(ready), 32'h0);
    run(bn, dn);
    check("t3_busy",  32'(bn), 32'd4);
    check("t3_out",   32'(out), 32'h0F);
    check("t3_ready", 32'(ready), 32'h1);

    // Start with empty FIFO
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_done_now", 32'(done), 32'h1);
    check("t4_busy_now", 32'(busy), 32'h0);
    tick();
    check("t4_done_end", 32'(done), 32'h0);
    check("t4_out",      32'(out),  32'h0F);

    // Double toggle returns to load value; load during RUN/DONE ignored
    do_load(8'h3C);
    do_push(8'h02);
    do_push(8'h02);
    start = 1'b1;
    tick();
    start = 1'b0;
    load  = 1'b1;
    a     = 8'hFF;
    check("t5_busy0", 32'(busy), 32'h1);
    tick();
    check("t5_out1",  32'(out), 32'h38);
    tick();
    check("t5_done",  32'(done), 32'h1);
    check("t5_out2",  32'(out), 32'h3C);
    tick();
    load = 1'b0;
    check("t5_idle",  32'(done), 32'h0);
    check("t5_out3",  32'(out), 32'h3C);

    // Push during the last pop keeps RUN; applied on the next edge
    do_load(8'h00);
    do_push(8'h01);
    start = 1'b1;
    tick();
    start = 1'b0;
    valid = 1'b1;
    b     = 8'h02;
    tick();
    valid = 1'b0;
    check("t6_busy", 32'(busy), 32'h1);
    check("t6_out1", 32'(out),  32'h02);
    tick();
    check("t6_done", 32'(done), 32'h1);
    check("t6_out2", 32'(out),  32'h06);
    tick();

    // Load beats start in IDLE
    do_push(8'h01);
    load  = 1'b1;
    a     = 8'h10;
    start = 1'b1;
    tick();
    load  = 1'b0;
    start = 1'b0;
    check("t7_busy", 32'(busy), 32'h0);
    check("t7_done", 32'(done), 32'h0);
    check("t7_out",  32'(out),  32'h10);
    run(bn, dn);
    check("t7_run_out", 32'(out), 32'h12);

    // Reset during the second RUN cycle
    do_load(8'h55);
    do_push(8'h00);
    do_push(8'h01);
    do_push(8'h02);
    do_push(8'h03);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("t8_mid_out", 32'(out), 32'h54);
    #2;
    rst_n = 1'b0;
    #1;
    check("t8_rst_out",   32'(out),   32'h00);
    check("t8_rst_ready", 32'(ready), 32'h1);
    check("t8_rst_busy",  32'(busy),  32'h0);
    check("t8_rst_done",  32'(done),  32'h0);
    #1;
    rst_n = 1'b1;
    dseen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done || busy) dseen++;
    end
    check("t8_no_done", 32'(dseen), 32'd0);
    check("t8_out",     32'(out),   32'h00);
    run(bn, dn);
    check("t8_empty_busy", 32'(bn), 32'd0);
    check("t8_empty_done", 32'(dn), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
